iap_sram_crc_snoop: RTL
=======================

Name: iap_sram_crc_snoop

Overview:
- Passive AHB-Lite snooper on the FIC_0 AMBA_SLAVE_0 bus, in parallel with the external-SRAM memory controller.
- Watches write transfers that land in a configured SRAM window while an IAP image is copied to external SRAM.
- Computes a running CRC-32 over the written bytes, in address order, and flags completion, match or sequencing error.
- Its status feeds the post-IAP device-restart logic, so a restart is issued only for a verified image.

Parameters:
- BASE_ADDR, 28'h0000000, byte address of the first image byte (word aligned).
- IMAGE_BYTES, 32'd1024, image length in bytes (1 .. 2^24).

Ports:
- CLK  in  1  FIC_0 clock (HCLK domain).
- RESETn  in  1  synchronous active-low reset.
- HADDR  in  28  AHB address, snooped.
- HTRANS  in  2  AHB transfer type, snooped.
- HWRITE  in  1  AHB write flag.
- HSIZE  in  3  AHB size (0 = byte, 1 = half, 2 = word).
- HWDATA  in  32  AHB write data.
- HSEL  in  1  slave select for the SRAM controller.
- HREADYIN  in  1  bus HREADY (transfer completes when high).
- HRESP  in  2  slave response; bit 0 set means ERROR.
- ARM  in  1  single-cycle pulse; clears and starts a capture.
- EXPECTED_CRC  in  32  reference CRC from image header.
- CRC_OUT  out  32  final CRC (running CRC while ARMED).
- BYTE_COUNT  out  25  bytes accumulated so far.
- BUSY  out  1  state == ARMED.
- DONE  out  1  state == DONE.
- MATCH  out  1  DONE and CRC_OUT == EXPECTED_CRC.
- SEQ_ERR  out  1  state == ERROR.

Behaviour:
- Reset (RESETn low at a CLK edge): state IDLE, CRC register 0xFFFFFFFF, count 0, expected address BASE_ADDR, pending phase cleared. CRC_OUT = 0x00000000; BUSY, DONE, MATCH and SEQ_ERR = 0. Reset mid-capture discards everything.
- Address phase is accepted when HSEL & HREADYIN & HTRANS[1] & HWRITE, and HADDR lies in [BASE_ADDR, BASE_ADDR+IMAGE_BYTES). Accepting it latches HADDR and HSIZE into a pending register. Any other accepted transfer (read, out of window) clears the pending register.
- Data phase completes on the first cycle with pending set and HREADYIN high. If HRESP[0]=1 at that point, the data is discarded. A new address phase in the same cycle loads pending normally (pipelined back-to-back).
- Lane selection: bytes taken are 1, 2 or 4 for HSIZE 0, 1, 2, taken from HWDATA starting at lane HADDR[1:0], little-endian, lowest address first. HSIZE > 2 is treated as a sequencing error.
- CRC: CRC-32, reflected polynomial 0xEDB88320, init 0xFFFFFFFF. Up to 4 bytes are folded in one cycle by an unrolled update. CRC_OUT = crc ^ 0xFFFFFFFF, registered, valid the cycle after the final data phase.
- States:
  - IDLE: ARM -> ARMED.
  - ARMED: on each completed data phase:
    - latched address != expected address -> ERROR;
    - count + nbytes > IMAGE_BYTES -> ERROR;
    - otherwise update CRC, count += nbytes, expected += nbytes;
    - count reaching exactly IMAGE_BYTES -> DONE.
  - DONE / ERROR: hold outputs until ARM or reset.
- ARM in any state: CRC = 0xFFFFFFFF, count = 0, expected = BASE_ADDR, pending cleared, state ARMED, and all status outputs drop on the next cycle. If ARM coincides with a data phase, ARM wins and the data is not accumulated.
- Writes completing in IDLE, DONE or ERROR are ignored; the counters do not change.
- Address arithmetic is modulo 2^28; the window check uses a 29-bit compare so the window never wraps.
- The block never drives the bus: no HREADY or HRESP outputs.

Test Plan:
1. Reset, then ARM with IMAGE_BYTES=9, BASE=0. Write word 0x34333231 @0, word 0x38373635 @4, byte 0x39 @8 (lane 0). Required: DONE=1, CRC_OUT=0xCBF43926, BYTE_COUNT=9, MATCH=1 when EXPECTED_CRC=0xCBF43926.
2. Same bytes as test 1 sent as halfwords 0x3231@0, 0x3433@2, ... then byte @8, back-to-back with HREADYIN held high. Required: identical CRC 0xCBF43926, no missed phases.
3. ARMED, first write @4 instead of @0. Required: SEQ_ERR=1 next cycle, BUSY=0, BYTE_COUNT=0. A following ARM returns BUSY=1 and SEQ_ERR=0.
4. Wait states: HREADYIN low 3 cycles in the data phase, with HWDATA changing during the wait. Required: only the value present on the HREADYIN-high cycle is accumulated. A data phase with HRESP=ERROR is not accumulated.
5. Reads and writes outside the window interleaved in the test 1 sequence. Required: result unchanged (0xCBF43926). Write @8 as a word when IMAGE_BYTES=9. Required: SEQ_ERR=1.
6. RESETn low mid-capture (count=4), then ARM and rerun test 1. Required: all outputs 0 during reset, then final CRC 0xCBF43926.

Source files
------------

// File: rtl/iap_sram_crc_snoop.sv
// Passive AHB-Lite write snooper: folds image bytes written into an SRAM window
// into a CRC-32 and reports done / match / sequencing error for restart gating.
module iap_sram_crc_snoop #(
  parameter logic [27:0] BASE_ADDR   = 28'h0000000,
  parameter logic [31:0] IMAGE_BYTES = 32'd1024
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [27:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HSEL,
  input  logic        HREADYIN,
  input  logic [1:0]  HRESP,
  input  logic        ARM,
  input  logic [31:0] EXPECTED_CRC,
  output logic [31:0] CRC_OUT,
  output logic [24:0] BYTE_COUNT,
  output logic        BUSY,
  output logic        DONE,
  output logic        MATCH,
  output logic        SEQ_ERR
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE, S_ERROR} state_t;

  // 29-bit bounds so a window ending at the top of the address space never wraps
  localparam logic [28:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [28:0] WIN_HI = WIN_LO + IMAGE_BYTES[28:0];

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d, crc_out_q;
  logic [24:0] cnt_q, cnt_d;
  logic [27:0] exp_q, exp_d;
  logic        pend_q, pend_d;
  logic [27:0] paddr_q, paddr_d;
  logic [2:0]  psize_q, psize_d;

  logic        addr_ok, dphase, bad_size;
  logic [2:0]  nbytes;
  logic [31:0] lanes, sum;

  logic unused_bits;
  assign unused_bits = &{1'b0, HTRANS[0], HRESP[1]};

  function automatic logic [31:0] crc_fold(input logic [31:0] crc,
                                           input logic [31:0] data,
                                           input logic [2:0]  n);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < n) begin
        c = c ^ {24'h000000, data[8*i +: 8]};
        for (int b = 0; b < 8; b++)
          c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return c;
  endfunction

  always_comb begin
    addr_ok = HSEL & HREADYIN & HTRANS[1] & HWRITE &
              ({1'b0, HADDR} >= WIN_LO) & ({1'b0, HADDR} < WIN_HI);
    dphase  = pend_q & HREADYIN & ~HRESP[0];

    bad_size = 1'b0;
    case (psize_q)
      3'd0:    nbytes = 3'd1;
      3'd1:    nbytes = 3'd2;
      3'd2:    nbytes = 3'd4;
      default: begin nbytes = 3'd0; bad_size = 1'b1; end
    endcase

    // lowest-addressed byte of the transfer moved down to lane 0
    lanes = HWDATA >> {paddr_q[1:0], 3'b000};
    sum   = 32'(cnt_q) + 32'(nbytes);

    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    pend_d  = pend_q;
    paddr_d = paddr_q;
    psize_d = psize_q;

    // a completing bus cycle retires the old data phase and opens the next one
    if (HREADYIN) begin
      pend_d = addr_ok;
      if (addr_ok) begin
        paddr_d = HADDR;
        psize_d = HSIZE;
      end
    end

    if (state_q == S_ARMED && dphase) begin
      if (bad_size || paddr_q != exp_q || sum > IMAGE_BYTES) begin
        state_d = S_ERROR;
      end else begin
        crc_d = crc_fold(crc_q, lanes, nbytes);
        cnt_d = sum[24:0];
        exp_d = exp_q + 28'(nbytes);
        if (sum == IMAGE_BYTES) state_d = S_DONE;
      end
    end

    if (ARM) begin
      state_d = S_ARMED;
      crc_d   = 32'hFFFFFFFF;
      cnt_d   = '0;
      exp_d   = BASE_ADDR;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q   <= S_IDLE;
      crc_q     <= 32'hFFFFFFFF;
      crc_out_q <= 32'h00000000;
      cnt_q     <= '0;
      exp_q     <= BASE_ADDR;
      pend_q    <= 1'b0;
      paddr_q   <= '0;
      psize_q   <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      crc_out_q <= ~crc_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      pend_q    <= pend_d;
      paddr_q   <= paddr_d;
      psize_q   <= psize_d;
    end
  end

  assign CRC_OUT    = crc_out_q;
  assign BYTE_COUNT = cnt_q;
  assign BUSY       = (state_q == S_ARMED);
  assign DONE       = (state_q == S_DONE);
  assign SEQ_ERR    = (state_q == S_ERROR);
  assign MATCH      = DONE && (crc_out_q == EXPECTED_CRC);

endmodule
